// File: rtl/xor_cipher_pkg.sv
// Shared types and defaults for the XOR cipher deserialiser slice.
package xor_cipher_pkg;

    localparam int unsigned DEFAULT_WORD_W = 8;
    localparam int unsigned DEFAULT_LEN_W  = $clog2(DEFAULT_WORD_W + 1);

    typedef struct packed {
        logic                      last;
        logic [DEFAULT_LEN_W-1:0]  len;
        logic [DEFAULT_WORD_W-1:0] word;
    } deser_entry_t;

endpackage

// File: rtl/xor_deser_fifo.sv
// Small first-word-fall-through FIFO with sticky overflow on dropped pushes.
module xor_deser_fifo
    import xor_cipher_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = deser_entry_t
) (
    input  logic   iClk,
    input  logic   iRst,
    input  logic   iPush,
    input  entry_t iEntry,
    input  logic   iPop,
    output entry_t oHead,
    output logic   oEmpty,
    output logic   oOverflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        full;
    logic        doPop;
    logic        doPush;

    assign oEmpty = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = iPop && !oEmpty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign doPush = iPush && (!full || doPop);
    assign oHead  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            oOverflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= iEntry;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (iPush && !doPush) begin
                oOverflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_cipher_deser.sv
// Packs the cipher's serial output into words and tags end-of-message entries.
module xor_cipher_deser
    import xor_cipher_pkg::*;
#(
    parameter int unsigned WORD_W     = DEFAULT_WORD_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iEn,
    input  logic                         iClk_slow,
    input  logic                         iData_bit,
    input  logic                         iDone_flag,
    output logic [WORD_W-1:0]            oWord,
    output logic [$clog2(WORD_W+1)-1:0]  oLen,
    output logic                         oLast,
    output logic                         oValid,
    input  logic                         iReady,
    output logic                         oOverflow,
    output logic                         oBusy
);

    localparam int unsigned LEN_W = $clog2(WORD_W + 1);
    localparam int unsigned POS_W = $clog2(WORD_W);

    typedef struct packed {
        logic              last;
        logic [LEN_W-1:0]  len;
        logic [WORD_W-1:0] word;
    } entry_t;

    logic              slowQ;
    logic              doneQ;
    logic              armedQ;
    logic [LEN_W-1:0]  cntQ;
    logic [WORD_W-1:0] asmQ;

    logic              sampleEv;
    logic              doneEv;
    logic [POS_W-1:0]  pos;
    logic [LEN_W-1:0]  cntAfter;
    logic [WORD_W-1:0] wordAfter;
    logic              wordComplete;
    logic              push;
    logic              fifoEmpty;
    entry_t            pushEntry;
    entry_t            head;

    // armedQ masks the first post-reset cycle, when slowQ/doneQ are not yet loaded.
    assign sampleEv = armedQ && iEn && iClk_slow && !slowQ;
    assign doneEv   = armedQ && iEn && iDone_flag && !doneQ;

    // Bits are written straight to their final position, so a partial word is
    // already zero-padded and needs no realignment.
    always_comb begin
        cntAfter  = cntQ;
        wordAfter = asmQ;
        pos       = MSB_FIRST ? POS_W'(WORD_W - 1) - POS_W'(cntQ) : POS_W'(cntQ);
        if (sampleEv) begin
            cntAfter       = cntQ + 1'b1;
            wordAfter[pos] = iData_bit;
        end
        wordComplete   = sampleEv && (cntAfter == LEN_W'(WORD_W));
        push           = wordComplete || doneEv;
        pushEntry.last = doneEv;
        pushEntry.len  = cntAfter;
        pushEntry.word = wordAfter;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            slowQ  <= 1'b0;
            doneQ  <= 1'b0;
            armedQ <= 1'b0;
            cntQ   <= '0;
            asmQ   <= '0;
        end else begin
            slowQ  <= iClk_slow;
            doneQ  <= iDone_flag;
            armedQ <= 1'b1;
            if (push) begin
                cntQ <= '0;
                asmQ <= '0;
            end else begin
                cntQ <= cntAfter;
                asmQ <= wordAfter;
            end
        end
    end

    xor_deser_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) uFifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (push),
        .iEntry    (pushEntry),
        .iPop      (iReady),
        .oHead     (head),
        .oEmpty    (fifoEmpty),
        .oOverflow (oOverflow)
    );

    assign oWord  = head.word;
    assign oLen   = head.len;
    assign oLast  = head.last;
    assign oValid = !fifoEmpty;
    assign oBusy  = (cntQ != '0);

endmodule

// File: tb/tb_xor_cipher_deser.sv
// Scoreboard bench for xor_cipher_deser with default parameters (8-bit, depth 4, MSB first).
module tb_xor_cipher_deser;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iEn = 1'b1;
    logic       iClk_slow = 1'b0;
    logic       iData_bit = 1'b0;
    logic       iDone_flag = 1'b0;
    logic       iReady = 1'b1;
    logic [7:0] oWord;
    logic [3:0] oLen;
    logic       oLast;
    logic       oValid;
    logic       oOverflow;
    logic       oBusy;

    typedef struct {
        logic [7:0] word;
        logic [3:0] len;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   miscompares = 0;
    int   validCycles = 0;

    xor_cipher_deser #(
        .WORD_W     (8),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (1'b1)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iClk_slow  (iClk_slow),
        .iData_bit  (iData_bit),
        .iDone_flag (iDone_flag),
        .oWord      (oWord),
        .oLen       (oLen),
        .oLast      (oLast),
        .oValid     (oValid),
        .iReady     (iReady),
        .oOverflow  (oOverflow),
        .oBusy      (oBusy)
    );

    always #5 iClk = ~iClk;

    // Pop side of the scoreboard: every accepted head entry is compared.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oValid) validCycles++;
            if (oValid && iReady) begin
                vecs++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pop: got word=%h len=%0d last=%b, required no entry",
                             oWord, oLen, oLast);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({oWord, oLen, oLast} !== {e.word, e.len, e.last}) begin
                        miscompares++;
                        $display("FAIL entry: got word=%h len=%0d last=%b, required word=%h len=%0d last=%b",
                                 oWord, oLen, oLast, e.word, e.len, e.last);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #2;
    endtask

    task automatic expect_entry(input logic [7:0] w, input logic [3:0] l, input logic last);
        exp_t e;
        e.word = w;
        e.len  = l;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic slowEdge(input logic b, input logic withDone);
        iData_bit = b;
        iClk_slow = 1'b1;
        if (withDone) iDone_flag = 1'b1;
        tick(2);
        iClk_slow  = 1'b0;
        iDone_flag = 1'b0;
        tick(2);
    endtask

    task automatic pulseDone();
        iDone_flag = 1'b1;
        tick(2);
        iDone_flag = 1'b0;
        tick(2);
    endtask

    task automatic sendWord(input logic [7:0] w, input logic doneOnLast);
        for (int i = 7; i >= 0; i--) begin
            slowEdge(w[i], doneOnLast && (i == 0));
        end
    endtask

    task automatic drain(input string name);
        int budget = 50;
        while (sb.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(2);
        vecs++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d entries outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        tick(3);
        vecs++;
        if ({oValid, oOverflow, oBusy, oWord, oLen, oLast} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b ovf=%b busy=%b word=%h len=%0d last=%b, required all 0",
                     oValid, oOverflow, oBusy, oWord, oLen, oLast);
        end
        iRst = 1'b0;
        tick(2);
    endtask

    task automatic test_full_word();
        expect_entry(8'hB2, 4'd8, 1'b0);
        validCycles = 0;
        sendWord(8'hB2, 1'b0);
        tick(2);
        vecs++;
        if (validCycles !== 1) begin
            miscompares++;
            $display("FAIL full_word_valid_cycles: got %0d, required 1", validCycles);
        end
        drain("full_word");
    endtask

    task automatic test_partial_tail();
        expect_entry(8'hC0, 4'd3, 1'b1);
        slowEdge(1'b1, 1'b0);
        slowEdge(1'b1, 1'b0);
        slowEdge(1'b0, 1'b0);
        vecs++;
        if (oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_busy_high: got %b, required 1", oBusy);
        end
        pulseDone();
        vecs++;
        if (oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_busy_low: got %b, required 0", oBusy);
        end
        drain("partial_tail");
    endtask

    task automatic test_done_coincident();
        expect_entry(8'h5A, 4'd8, 1'b1);
        sendWord(8'h5A, 1'b1);
        tick(4);
        drain("done_coincident");
    endtask

    task automatic test_terminator();
        expect_entry(8'h3C, 4'd8, 1'b0);
        expect_entry(8'h00, 4'd0, 1'b1);
        sendWord(8'h3C, 1'b0);
        pulseDone();
        drain("terminator");
    endtask

    task automatic test_back_to_back();
        iReady = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            expect_entry(8'(w), 4'd8, 1'b0);
            sendWord(8'(w), 1'b0);
        end
        vecs++;
        if (oOverflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_early: got %b, required 0", oOverflow);
        end
        sendWord(8'h05, 1'b0);
        vecs++;
        if ({oOverflow, oValid} !== 2'b11) begin
            miscompares++;
            $display("FAIL overflow_set: got ovf=%b valid=%b, required ovf=1 valid=1", oOverflow, oValid);
        end
        iReady = 1'b1;
        drain("back_to_back");
        vecs++;
        if ({oOverflow, oValid} !== 2'b10) begin
            miscompares++;
            $display("FAIL overflow_sticky: got ovf=%b valid=%b, required ovf=1 valid=0", oOverflow, oValid);
        end
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 5; i++) slowEdge(1'b1, 1'b0);
        iRst = 1'b1;
        tick(1);
        iRst = 1'b0;
        vecs++;
        if ({oBusy, oValid, oOverflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_word: got busy=%b valid=%b ovf=%b, required 0 0 0", oBusy, oValid, oOverflow);
        end
        tick(2);
        expect_entry(8'hA5, 4'd8, 1'b0);
        sendWord(8'hA5, 1'b0);
        drain("reset_mid_word");
    endtask

    task automatic test_enable();
        iEn = 1'b0;
        slowEdge(1'b1, 1'b0);
        iClk_slow = 1'b1;
        tick(2);
        iEn = 1'b1;
        tick(2);
        iClk_slow = 1'b0;
        tick(2);
        vecs++;
        if ({oBusy, oValid} !== 2'b00) begin
            miscompares++;
            $display("FAIL enable_gating: got busy=%b valid=%b, required 0 0", oBusy, oValid);
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_full_word();
        test_partial_tail();
        test_done_coincident();
        test_terminator();
        test_back_to_back();
        test_reset_mid_word();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
